// File: rtl/logic_unit_pkg.sv
// Shared opcode and state encodings for the arbitrated logic unit.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package logic_unit_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/logic_unit.sv
// Registered two-input logic unit: po_c <= op(pi_a, pi_b) when enabled.
// Latency: 1 cycle from pi_en to po_c.
// Backpressure: none; po_c holds its value while pi_en is low.
module logic_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pi_a,
  input  logic       pi_b,
  input  logic [1:0] pi_op,
  input  logic       pi_en,
  output logic       po_c
);

  import logic_unit_pkg::*;

  // Evaluate the selected boolean operation into the result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      po_c <= 1'b0;
    end else if (pi_en) begin
      case (pi_op)
        OP_AND:  po_c <= pi_a & pi_b;
        OP_OR:   po_c <= pi_a | pi_b;
        OP_XOR:  po_c <= pi_a ^ pi_b;
        default: po_c <= ~(pi_a & pi_b);
      endcase
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered logic unit among NUM_REQ requesters.
// Latency: grant 1 cycle after sampled request, ack with result 2 cycles after; 3 cycles per transaction.
// Backpressure: requests are level-held until ack; losing requesters simply stay pending.
module logic_unit_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   pi_req,
  input  logic [NUM_REQ-1:0]   pi_a,
  input  logic [NUM_REQ-1:0]   pi_b,
  input  logic [2*NUM_REQ-1:0] pi_op,
  output logic [NUM_REQ-1:0]   po_gnt,
  output logic [NUM_REQ-1:0]   po_ack,
  output logic                 po_c,
  output logic                 po_busy
);

  import logic_unit_pkg::*;

  state_t               state_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [PTR_W-1:0]     gidx_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic                 a_q;
  logic                 b_q;
  logic [1:0]           op_q;

  logic                 sel_vld;
  logic [PTR_W-1:0]     sel_idx;
  logic                 sel_a;
  logic                 sel_b;
  logic [1:0]           sel_op;
  logic                 lu_en;

  // Cyclic priority search from the pointer; iterating backwards lets the
  // first hit at or after the pointer be the last (winning) assignment.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = ptr_q;
    sel_a   = 1'b0;
    sel_b   = 1'b0;
    sel_op  = 2'b00;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pi_req[(int'(ptr_q) + i) % NUM_REQ]) begin
        sel_vld = 1'b1;
        sel_idx = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
        sel_a   = pi_a[(int'(ptr_q) + i) % NUM_REQ];
        sel_b   = pi_b[(int'(ptr_q) + i) % NUM_REQ];
        sel_op  = pi_op[2 * ((int'(ptr_q) + i) % NUM_REQ) +: 2];
      end
    end
  end

  // Transaction FSM: grant and capture operands, execute, then acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      gnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      op_q    <= 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_vld) begin
            gnt_q   <= NUM_REQ'(1) << sel_idx;
            gidx_q  <= sel_idx;
            a_q     <= sel_a;
            b_q     <= sel_b;
            op_q    <= sel_op;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          gnt_q   <= '0;
          ptr_q   <= (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);
          state_q <= ST_IDLE;
        end
        default: begin
          gnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign lu_en   = (state_q == ST_EXEC);
  assign po_gnt  = gnt_q;
  assign po_ack  = (state_q == ST_DONE) ? gnt_q : '0;
  assign po_busy = (state_q != ST_IDLE);

  logic_unit u_logic_unit (
    .clk   (clk),
    .rst_n (rst_n),
    .pi_a  (a_q),
    .pi_b  (b_q),
    .pi_op (op_q),
    .pi_en (lu_en),
    .po_c  (po_c)
  );

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: transaction-level reference model plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_logic_unit_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   pi_req;
  logic [N-1:0]   pi_a;
  logic [N-1:0]   pi_b;
  logic [2*N-1:0] pi_op;
  logic [N-1:0]   po_gnt;
  logic [N-1:0]   po_ack;
  logic           po_c;
  logic           po_busy;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.NUM_REQ(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pi_req  (pi_req),
    .pi_a    (pi_a),
    .pi_b    (pi_b),
    .pi_op   (pi_op),
    .po_gnt  (po_gnt),
    .po_ack  (po_ack),
    .po_c    (po_c),
    .po_busy (po_busy)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int ack_idx[$];
  int ack_cyc[$];

  // Reference model: a transaction occupies 'age' 0 (granted) and 1 (acked)
  int   m_age = -1;
  int   m_ptr = 0;
  int   m_g   = 0;
  logic m_res = 1'b0;
  logic [N-1:0] e_gnt;
  logic [N-1:0] e_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic ref_op(input logic [1:0] op, input logic a, input logic b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int k = 0; k < N; k++) if (v[k]) r = k;
    return r;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age = -1;
      m_ptr = 0;
    end else if (m_age == 1) begin
      m_ptr = (m_g + 1) % N;
      m_age = -1;
    end else if (m_age == 0) begin
      m_age = 1;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (m_age < 0 && pi_req[(m_ptr + k) % N]) begin
          m_g   = (m_ptr + k) % N;
          m_age = 0;
          m_res = ref_op(pi_op[2*m_g +: 2], pi_a[m_g], pi_b[m_g]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      e_gnt = (m_age >= 0) ? (N'(1) << m_g) : '0;
      e_ack = (m_age == 1) ? (N'(1) << m_g) : '0;
      chk("model_gnt", 32'(po_gnt), 32'(e_gnt));
      chk("model_ack", 32'(po_ack), 32'(e_ack));
      chk("model_busy", 32'(po_busy), 32'(m_age >= 0));
      if (m_age == 1) chk("model_c", 32'(po_c), 32'(m_res));
      if (po_ack != '0) begin
        ack_idx.push_back(onehot_idx(po_ack));
        ack_cyc.push_back(cyc);
      end
    end
  end

  task automatic wait_ack(input string nm, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (po_ack != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      nvec++;
      nerr++;
      $display("FAIL %s_timeout: no ack within 20 cycles, one required", nm);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, completion required");
    $fatal(1, "watchdog");
  end

  logic [3:0] tt [4];
  int ord [5];

  initial begin
    bit ok;
    tt[0] = 4'b1000;
    tt[1] = 4'b1110;
    tt[2] = 4'b0110;
    tt[3] = 4'b0111;
    ord   = '{0, 1, 2, 3, 0};

    rst_n = 1'b0; pi_req = '0; pi_a = '0; pi_b = '0; pi_op = '0;
    #1;
    chk("rst_gnt", 32'(po_gnt), 0);
    chk("rst_ack", 32'(po_ack), 0);
    chk("rst_c", 32'(po_c), 0);
    chk("rst_busy", 32'(po_busy), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request
    pi_req = 4'b0001; pi_a = 4'b0001; pi_b = 4'b0001; pi_op = 8'h00;
    @(negedge clk);
    chk("single_gnt", 32'(po_gnt), 32'h1);
    chk("single_busy1", 32'(po_busy), 1);
    chk("single_noack", 32'(po_ack), 0);
    @(negedge clk);
    chk("single_ack", 32'(po_ack), 32'h1);
    chk("single_c", 32'(po_c), 1);
    chk("single_busy2", 32'(po_busy), 1);
    pi_req = '0;
    @(negedge clk);
    chk("single_idle", 32'(po_busy), 0);
    chk("single_gnt_clr", 32'(po_gnt), 0);

    // Truth table on requester 2
    for (int op = 0; op < 4; op++) begin
      for (int ab = 0; ab < 4; ab++) begin
        pi_req = 4'b0100;
        pi_a = '0; pi_b = '0; pi_op = '0;
        pi_a[2] = ab[1];
        pi_b[2] = ab[0];
        pi_op[5:4] = op[1:0];
        wait_ack("tt", ok);
        if (ok) begin
          chk("tt_ack", 32'(po_ack), 32'h4);
          chk("tt_c", 32'(po_c), 32'(tt[op][ab]));
        end
        pi_req = '0;
        @(negedge clk);
      end
    end

    // Round-robin with all requests held from reset release
    rst_n = 1'b0;
    pi_req = 4'hF;
    @(negedge clk); @(negedge clk);
    ack_idx.delete(); ack_cyc.delete();
    rst_n = 1'b1;
    repeat (16) @(negedge clk);
    chk("rr_count_ge5", 32'(ack_idx.size() >= 5), 1);
    for (int i = 0; i < 5; i++) begin
      if (i < ack_idx.size()) begin
        chk("rr_order", 32'(ack_idx[i]), 32'(ord[i]));
        if (i > 0) chk("rr_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 3);
      end
    end
    pi_req = '0;
    repeat (4) @(negedge clk);

    // Operand change after grant
    pi_req = 4'b0010; pi_a = 4'b0010; pi_b = 4'b0000; pi_op = 8'b0000_0100;
    @(negedge clk);
    chk("opchg_gnt", 32'(po_gnt), 32'h2);
    pi_a = '0; pi_b = '0;
    @(negedge clk);
    chk("opchg_ack", 32'(po_ack), 32'h2);
    chk("opchg_c", 32'(po_c), 1);
    pi_req = '0;
    @(negedge clk);

    // Request drop during EXEC, then a fresh request from requester 0
    pi_req = 4'b1000; pi_a = 4'b1000; pi_b = 4'b1000; pi_op = 8'b1100_0000;
    @(negedge clk);
    chk("drop_gnt", 32'(po_gnt), 32'h8);
    pi_req = '0;
    @(negedge clk);
    chk("drop_ack", 32'(po_ack), 32'h8);
    chk("drop_c", 32'(po_c), 0);
    pi_req = 4'b0001; pi_a = 4'b0001; pi_b = 4'b0000; pi_op = 8'b0000_0010;
    @(negedge clk);
    chk("drop_idle", 32'(po_busy), 0);
    @(negedge clk);
    chk("drop_next_gnt", 32'(po_gnt), 32'h1);
    @(negedge clk);
    chk("drop_next_ack", 32'(po_ack), 32'h1);
    chk("drop_next_c", 32'(po_c), 1);
    pi_req = '0;
    @(negedge clk);

    // Reset during EXEC
    pi_req = 4'b0100; pi_a = 4'b0100; pi_b = 4'b0000; pi_op = 8'b0001_0000;
    @(negedge clk);
    chk("rstmid_gnt", 32'(po_gnt), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_gnt0", 32'(po_gnt), 0);
    chk("rstmid_ack0", 32'(po_ack), 0);
    chk("rstmid_busy0", 32'(po_busy), 0);
    chk("rstmid_c0", 32'(po_c), 0);
    pi_req = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_noack", 32'(po_ack), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_first_gnt", 32'(po_gnt), 32'h1);
    pi_req = '0;
    repeat (4) @(negedge clk);

    // Randomized traffic against the model
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      pi_req = 4'($urandom);
      pi_a   = 4'($urandom);
      pi_b   = 4'($urandom);
      pi_op  = 8'($urandom);
      if (it == 1500) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    pi_req = '0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
